set_bit_scanner64: RTL and testbench
====================================

Name: set_bit_scanner64

Overview:
- Sequential set-bit index scanner for the datapath utility library.
- Accepts one WIDTH-bit word over a valid/ready handshake and emits the index of every set bit, one index per handshake beat, lowest index first.
- An all-zero word produces a single "none" beat. This is the same condition as a zero flag.
- Intended for register-list expansion, such as multi-register load/store sequencing and exception-cause scanning.

Parameters:
- WIDTH, 64, input word width; power of two, 2..64.
- IDXW, 6, index width; must equal log2(WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  the upstream word is valid.
- in_ready  output  1  the scanner can accept a word.
- in_data  input  WIDTH  word to scan.
- out_valid  output  1  an index beat is present.
- out_ready  input  1  downstream accepts the beat.
- out_idx  output  IDXW  bit index of the current set bit.
- out_last  output  1  final beat for the current word.
- out_none  output  1  the captured word was all zero; out_idx is 0 on this beat.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high. All registers update on the rising edge of clk only.
- Reset values: state=IDLE, mask=0, in_ready=0 while reset is asserted, out_valid=0, out_idx=0, out_last=0, out_none=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SCAN: in_ready=0, out_valid=1.
- Accept: in IDLE, in_valid&&in_ready captures in_data into the mask register. Next state is SCAN.
- Latency: the first beat appears one cycle after the accept.
- No combinational path from any input to any output. All outputs decode from the state and mask registers.
- SCAN outputs:
  - out_idx = index of the lowest set bit in mask.
  - out_none = (mask==0).
  - out_last = 1 when mask has at most one bit set.
- Beat handshake: out_valid&&out_ready completes a beat. The bit at out_idx is then cleared in mask.
  - If out_last: return to IDLE.
  - Otherwise: stay in SCAN.
- Backpressure: while out_ready=0, out_idx, out_last and out_none hold stable and out_valid stays 1.
- Throughput:
  - A word with k>0 set bits takes k beats; a zero word takes 1 beat.
  - With out_ready held at 1, a word occupies k+1 cycles including the IDLE accept cycle.
  - There is no overlap between the last beat and the next accept.
- in_valid during SCAN is ignored. No capture occurs, and upstream must hold its word.
- Zero word: exactly one beat, with out_none=1, out_last=1 and out_idx=0.
- Full word (all ones): WIDTH beats with indices 0..WIDTH-1 in order. out_last is set only on index WIDTH-1.
- When out_valid=0, out_idx, out_last and out_none are forced to 0.
- Reset mid-SCAN: the word is abandoned. Reset values apply on the next edge, and no further beats are emitted.
- Reset concurrent with in_valid: no capture occurs.
- Priority encoder: combinational over mask. Any structure is acceptable, including a tree of 2-input gates; it must settle within one cycle.

Optional Feature:
- Macro: SCANNER_MSB_FIRST_EN.
- Defined: scan order is reversed. out_idx is the highest set bit of mask, beats are emitted in descending index order, and out_last keeps the same definition.
- Undefined: lowest-index-first order as specified above.
- The port list, latency and zero-word behaviour are identical in both builds.

Test Plan:
- Zero word: in_data=64'h0 accepted → one beat with out_valid=1, out_none=1, out_last=1, out_idx=0; in_ready=1 on the following cycle.
- Sparse word: in_data=64'h8000_0000_0000_0001, out_ready=1 → beats idx=0 (last=0), then idx=63 (last=1); returns to IDLE.
- Full word: in_data=64'hFFFF_FFFF_FFFF_FFFF, out_ready=1 → 64 consecutive beats, idx 0..63; last=1 only on 63; in_ready=0 throughout.
- Backpressure: in_data=64'h110, out_ready=0 for 3 cycles → idx=4 held stable with out_valid=1; release → idx=4, then idx=8 with last=1. A second in_valid during SCAN is not captured.
- Reset mid-scan: in_data=64'hF0, reset asserted after the first beat → next cycle out_valid=0, in_ready=0; after deassert in_ready=1 and no stale beats appear.
- Macro build (SCANNER_MSB_FIRST_EN): in_data=64'h110 → idx=8 (last=0), then idx=4 (last=1); zero word behaves as in the first test.

Source files
------------

// File: rtl/set_bit_scanner64.sv
// set_bit_scanner64
// Accepts one WIDTH-bit word over a valid/ready handshake and emits the index
// of every set bit, one index per output beat. An all-zero word yields a single
// beat flagged out_none. Every output is a register; no input reaches an output
// without passing through a flop.
//
// Build option: define SCANNER_MSB_FIRST_EN to emit indices highest-first
// instead of lowest-first. Ports, latency and zero-word handling do not change.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready=1, waiting for a word; outputs quiet
// SCAN  | out_valid=1, presenting the selected set bit of mask_q

module set_bit_scanner64 #(
    parameter int WIDTH = 64,
    parameter int IDXW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             out_none
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    if (WIDTH != (1 << IDXW)) begin : g_param_check
        $error("set_bit_scanner64: WIDTH must equal 2**IDXW");
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [IDXW-1:0]   out_idx_q;
    logic              out_last_q;
    logic              out_none_q;

    // Selected bit of a mask: lowest set bit by default, highest when the
    // descending order is built in. Returns 0 for an empty mask.
    function automatic logic [IDXW-1:0] pick_index(input logic [WIDTH-1:0] m);
        logic [IDXW-1:0] idx;
        idx = '0;
`ifdef SCANNER_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (m[i]) idx = IDXW'(i);
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (m[i]) idx = IDXW'(i);
        end
`endif
        return idx;
    endfunction

    // True when at most one bit of the mask is set (clearing the lowest set
    // bit leaves nothing behind).
    function automatic logic at_most_one(input logic [WIDTH-1:0] m);
        return ((m & (m - ONE)) == '0);
    endfunction

    // Next state and next mask: capture on accept, clear the presented bit on
    // each completed beat, and leave SCAN after the last beat.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    mask_d  = in_data;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (out_ready) begin
                    // Clearing bit 0 of an empty mask is harmless, so the zero
                    // word needs no special case here.
                    mask_d = mask_q & ~(ONE << out_idx_q);
                    if (out_last_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, mask and registered outputs; outputs are precomputed from the
    // next state and next mask so they stay aligned with the registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_none_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_SCAN);
            if (state_d == ST_SCAN) begin
                out_idx_q  <= pick_index(mask_d);
                out_last_q <= at_most_one(mask_d);
                out_none_q <= (mask_d == '0);
            end else begin
                out_idx_q  <= '0;
                out_last_q <= 1'b0;
                out_none_q <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_none  = out_none_q;

endmodule

// File: tb/tb_set_bit_scanner64.sv
// Self-checking bench for set_bit_scanner64. A reference model expands each
// word into its expected beat list and queues it; a monitor pops one entry per
// completed output beat and compares.

module tb_set_bit_scanner64;

    localparam int WIDTH = 64;
    localparam int IDXW  = 6;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic            last;
        logic            none;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic             out_none;

    int    n_checks = 0;
    int    n_pass = 0;
    beat_t sb[$];
    beat_t mon_b;

    set_bit_scanner64 #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_none  (out_none)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expand a word into the beats the scanner must produce, in emission order.
    task automatic push_expect(input logic [WIDTH-1:0] w);
        int    idxs[$];
        beat_t b;
        if (w == '0) begin
            b.idx  = '0;
            b.last = 1'b1;
            b.none = 1'b1;
            sb.push_back(b);
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
`ifdef SCANNER_MSB_FIRST_EN
                if (w[i]) idxs.push_front(i);
`else
                if (w[i]) idxs.push_back(i);
`endif
            end
            for (int k = 0; k < idxs.size(); k++) begin
                b.idx  = IDXW'(idxs[k]);
                b.last = (k == idxs.size() - 1);
                b.none = 1'b0;
                sb.push_back(b);
            end
        end
    endtask

    // Present a word until accepted, then confirm the first beat one cycle later.
    // Called at posedge+1; returns at the negedge after the accepting edge.
    task automatic offer(input logic [WIDTH-1:0] w);
        int   budget;
        logic rdy;
        budget   = 0;
        in_data  = w;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end while (!rdy && budget < 50);
        in_valid = 1'b0;
        check("accept_timeout", rdy, 1);
        @(negedge clk);
        check("first_beat_latency", out_valid, 1);
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        push_expect(w);
        offer(w);
    endtask

    // Let the monitor consume all queued beats, optionally with random stalls,
    // then confirm the scanner is back in IDLE.
    task automatic drain(input bit stall);
        int budget;
        budget = 0;
        out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        while (sb.size() != 0 && budget < 2000) begin
            @(posedge clk);
            #1;
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            budget++;
        end
        check("drain_left", sb.size(), 0);
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed beat must match the head of the scoreboard;
    // outside SCAN the beat fields must read zero.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                check("in_ready_in_scan", in_ready, 0);
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_beat", out_valid, 0);
                    end else begin
                        mon_b = sb.pop_front();
                        check("beat_idx", out_idx, mon_b.idx);
                        check("beat_last", out_last, mon_b.last);
                        check("beat_none", out_none, mon_b.none);
                    end
                end
            end else begin
                check("quiet_outputs", {out_idx, out_last, out_none}, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        beat_t b;
        logic [WIDTH-1:0] w;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_none", out_none, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Zero word, sparse word, full word
        send(64'h0);
        drain(0);
        send(64'h8000_0000_0000_0001);
        drain(0);
        send(64'hFFFF_FFFF_FFFF_FFFF);
        drain(0);

        // Backpressure with a second word offered during SCAN
        out_ready = 1'b0;
        send(64'h110);
        @(posedge clk);
        #1;
        in_data  = 64'hFF;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
`ifdef SCANNER_MSB_FIRST_EN
            check("bp_idx", out_idx, 8);
`else
            check("bp_idx", out_idx, 4);
`endif
            check("bp_last", out_last, 0);
            check("bp_none", out_none, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain(0);

        // Reset after the first beat of a multi-bit word
        b.none = 1'b0;
        b.last = 1'b0;
`ifdef SCANNER_MSB_FIRST_EN
        b.idx = 6'd7;
`else
        b.idx = 6'd4;
`endif
        sb.push_back(b);
        out_ready = 1'b1;
        offer(64'hF0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_sb_empty", sb.size(), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("postrst_in_ready", in_ready, 1);
        check("postrst_out_valid", out_valid, 0);
        repeat (5) @(posedge clk);
        #1;

        // Reset concurrent with in_valid must not capture
        reset    = 1'b1;
        in_data  = 64'hFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_valid_no_capture", out_valid, 0);
        repeat (4) @(posedge clk);
        #1;

        // Random words with random output stalls
        for (int n = 0; n < 6; n++) begin
            w = {$urandom, $urandom};
            if (n % 2 == 1) w = w & {$urandom, $urandom} & {$urandom, $urandom};
            send(w);
            drain(1);
        end

        // Single-bit boundary words
        send(64'h1);
        drain(0);
        send(64'h8000_0000_0000_0000);
        drain(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
